// File: rtl/spi_target.sv
// SPI mode-3 target: pins are synchronised into the clk domain, then a two-state
// frame FSM drives byte-wide receive/transmit handshakes and frame status.
module spi_target #(
    parameter logic [7:0] TX_IDLE = 8'hff
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_di,
    output logic       spi_do,
    output logic       spi_do_oe,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic       rx_ack,
    output logic       rx_ovr,
    input  logic [7:0] tx_dat,
    input  logic       tx_we,
    output logic       tx_rdy,
    output logic       tx_und,
    input  logic       stat_clr,
    output logic       sel,
    output logic       frm_start,
    output logic       frm_end,
    output logic [9:0] frm_cnt
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       go_active, go_idle;
    logic       cs_p0, cs_p1, cs_p2;
    logic       ck_p0, ck_p1, ck_p2;
    logic       di_p0, di_p1, di_p2;
    logic       vld_p0, vld_p1;
    logic       armed;
    logic       cs_fall, cs_rise, ck_fall, ck_rise;
    logic [2:0] bit_cnt;
    logic [7:0] hold;
    logic [7:0] tx_sr;
    logic [6:0] rx_sr;
    logic [7:0] rx_byte;
    logic       act_fall, act_rise;

    // Stage p0/p1: two-flop synchronisers; p2: edge-detect register
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_p0  <= 1'b1;
            cs_p1  <= 1'b1;
            cs_p2  <= 1'b1;
            ck_p0  <= 1'b1;
            ck_p1  <= 1'b1;
            ck_p2  <= 1'b1;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            armed  <= 1'b0;
        end else begin
            cs_p0  <= spi_cs_n;
            cs_p1  <= cs_p0;
            cs_p2  <= cs_p1;
            ck_p0  <= spi_clk;
            ck_p1  <= ck_p0;
            ck_p2  <= ck_p1;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            // A frame may only open once real pin data has shown cs_n high.
            armed  <= armed | (vld_p1 & cs_p1);
        end
    end

    always_ff @(posedge clk) begin
        di_p0 <= spi_di;
        di_p1 <= di_p0;
        di_p2 <= di_p1;
    end

    assign cs_fall  = armed & cs_p2 & ~cs_p1;
    assign cs_rise  = cs_p1 & ~cs_p2;
    assign ck_fall  = ck_p2 & ~ck_p1;
    assign ck_rise  = ck_p1 & ~ck_p2;
    assign act_fall = (state == ACTIVE) && ck_fall;
    assign act_rise = (state == ACTIVE) && ck_rise;
    assign rx_byte  = {rx_sr, di_p2};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go_active = 1'b0;
        go_idle   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = ACTIVE;
                    go_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_nxt = IDLE;
                    go_idle   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p3: control and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_dat    <= 8'h00;
            rx_vld    <= 1'b0;
            rx_ovr    <= 1'b0;
            tx_rdy    <= 1'b1;
            tx_und    <= 1'b0;
            frm_start <= 1'b0;
            frm_end   <= 1'b0;
            frm_cnt   <= 10'd0;
            bit_cnt   <= 3'd0;
        end else begin
            frm_start <= go_active;
            frm_end   <= go_idle;
            if (stat_clr) begin
                rx_ovr <= 1'b0;
                tx_und <= 1'b0;
            end
            if (rx_ack && rx_vld) rx_vld <= 1'b0;
            if (tx_we && tx_rdy)  tx_rdy <= 1'b0;
            if (go_active) begin
                bit_cnt <= 3'd0;
                frm_cnt <= 10'd0;
            end
            if (act_fall && bit_cnt == 3'd0) begin
                if (!tx_rdy) tx_rdy <= 1'b1;
                else         tx_und <= 1'b1;
            end
            if (act_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    frm_cnt <= frm_cnt + 10'd1;
                    if (!rx_vld || rx_ack) begin
                        rx_dat <= rx_byte;
                        rx_vld <= 1'b1;
                    end else begin
                        rx_ovr <= 1'b1;
                    end
                end
            end
            // Closing the frame throws away any partially shifted byte.
            if (go_idle) bit_cnt <= 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_we && tx_rdy) hold <= tx_dat;
        if (act_fall) begin
            if (bit_cnt == 3'd0) tx_sr <= tx_rdy ? TX_IDLE : hold;
            else                 tx_sr <= {tx_sr[6:0], 1'b0};
        end
        if (act_rise) rx_sr <= rx_byte[6:0];
    end

    assign sel       = (state == ACTIVE);
    assign spi_do_oe = sel;
    assign spi_do    = sel ? tx_sr[7] : 1'b1;

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter TX_IDLE, default 8'hff, byte shifted out when no transmit data is queued.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports spi_cs_n in 1 (chip select, active low), spi_clk in 1 (SPI clock), spi_di in 1 (MOSI); all asynchronous to clk.
REQ-005 SHALL have ports spi_do out 1 (MISO) and spi_do_oe out 1 (MISO output enable).
REQ-006 SHALL have ports rx_dat out 8 (received byte), rx_vld out 1 (byte held), rx_ack in 1 (consume byte), rx_ovr out 1 (sticky overrun flag).
REQ-007 SHALL have ports tx_dat in 8 (byte to send), tx_we in 1 (write strobe), tx_rdy out 1 (holding register empty), tx_und out 1 (sticky underrun flag).
REQ-008 SHALL have ports stat_clr in 1 (clears rx_ovr and tx_und), sel out 1 (frame active), frm_start out 1 (pulse), frm_end out 1 (pulse), frm_cnt out 10 (bytes completed in frame).

Function
REQ-009 SHALL pass spi_cs_n, spi_clk and spi_di each through a 2-FF synchronizer followed by one edge-detect register; pin-to-event latency SHALL be 3 clk cycles.
REQ-010 SHALL implement SPI mode 3 (CPOL=1, CPHA=1): data sampled on spi_clk rising edges, driven on falling edges, MSB first, 8-bit bytes.
REQ-011 SHALL operate correctly when spi_clk high and low phases are each >= 3 clk cycles; behaviour below this is undefined.
REQ-012 SHALL use a two-state FSM: IDLE (synced cs_n=1) and ACTIVE (synced cs_n=0).
REQ-013 IDLE->ACTIVE on synced cs_n falling: frm_start=1 for one cycle, sel=1, bit counter=0, frm_cnt=0.
REQ-014 ACTIVE->IDLE on synced cs_n rising: frm_end=1 for one cycle, sel=0, any partial byte discarded, bit counter=0; frm_cnt holds until next frm_start.
REQ-015 SHALL ignore spi_clk edges in IDLE.
REQ-016 On each falling spi_clk edge in ACTIVE with bit counter=0, SHALL load the transmit shift register from the holding register (tx_rdy->1 same cycle) or, if empty, with TX_IDLE and set tx_und.
REQ-017 On other falling edges in ACTIVE, SHALL shift the transmit shift register left by one.
REQ-018 spi_do SHALL equal transmit shift register bit 7 while spi_do_oe=1, else 1; spi_do_oe SHALL equal sel.
REQ-019 On each rising spi_clk edge in ACTIVE, SHALL shift the synced spi_di into the receive shift register LSB and increment the bit counter (3 bits, wraps 7->0).
REQ-020 On the rising edge completing bit 8: if rx_vld=0 or rx_ack=1 that cycle, rx_dat<=byte and rx_vld<=1; otherwise rx_dat and rx_vld unchanged, byte dropped, rx_ovr<=1.
REQ-021 rx_ack with rx_vld=1 and no simultaneous completion SHALL clear rx_vld next cycle; rx_ack with rx_vld=0 SHALL be ignored.
REQ-022 frm_cnt SHALL increment by 1 per completed byte (dropped bytes included), wrapping 1023->0.
REQ-023 tx_we with tx_rdy=1 SHALL load tx_dat into the holding register and clear tx_rdy next cycle; tx_we with tx_rdy=0 SHALL be ignored.
REQ-024 tx_we in the same cycle as an empty-holding-register load (REQ-016) SHALL write the holding register; the shift register takes TX_IDLE and tx_und is set.
REQ-025 stat_clr SHALL clear rx_ovr and tx_und; a simultaneous set event SHALL win.
REQ-026 The holding register SHALL persist across frames; it is not flushed by frm_end.

Reset
REQ-027 With rst=1 at a clk edge, SHALL set: spi_do=1, spi_do_oe=0, rx_dat=0, rx_vld=0, rx_ovr=0, tx_rdy=1, tx_und=0, sel=0, frm_start=0, frm_end=0, frm_cnt=0, FSM=IDLE.
REQ-028 Synchronizers SHALL reset to idle levels (cs_n=1, spi_clk=1), so no spurious edge follows reset release.
REQ-029 rst asserted mid-frame SHALL abort without frm_end; after release with spi_cs_n low, a new frame starts only after a subsequent cs_n high-then-low.

Verification
REQ-030 tx_we 8'hA5 then frame of one byte MOSI 8'h3C, spi_clk half-period 4 clk -> MISO 10100101, rx_dat=8'h3C, rx_vld=1, frm_cnt=1, frm_start/frm_end one pulse each.
REQ-031 Two-byte frame with no tx_we -> MISO 8'hFF twice, tx_und=1; stat_clr -> tx_und=0.
REQ-032 Two bytes 8'h11, 8'h22 without rx_ack -> rx_dat=8'h11, rx_ovr=1, frm_cnt=2; rx_ack at second completion instead -> rx_dat=8'h22, rx_ovr=0.
REQ-033 cs_n deasserted after 5 bits -> no rx_vld, frm_end pulse, next frame byte 8'h81 received intact.
REQ-034 rst pulsed mid-byte with cs_n low -> all outputs at REQ-027 values; no frame until cs_n toggles.
REQ-035 tx_we while tx_rdy=0 (8'h55 queued, write 8'hAA) -> MISO shows 8'h55.
